// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round counts, key type, FSM states,
// and the byte substitution and round-constant helpers.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int NUM_RKEYS  = 11;
  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  typedef logic [127:0] rkey_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  // Forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] bit_idx;
    bit_idx = {x, 3'b000};
    return SBOX_TABLE[11'd2047 - bit_idx -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round_number);
    case (round_number)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/key_round_step.sv
// One AES-128 key-schedule step: keyScheduleCore on the last word of the
// previous round key followed by the four-word XOR chain.
module key_round_step
  import aes_pkg::*;
(
  input  rkey_t      prev_key,
  input  logic [3:0] round_number,
  output rkey_t      next_key
);

  logic [31:0] rot_word;
  logic [31:0] sub_word;
  logic [31:0] core_word;

  assign rot_word = {prev_key[23:0], prev_key[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sub
    assign sub_word[8*gi +: 8] = sbox(rot_word[8*gi +: 8]);
  end

  assign core_word = sub_word ^ {rcon(round_number), 24'h000000};

  // Each new word depends on the new word to its left, so the chain ripples.
  assign next_key[127:96] = prev_key[127:96] ^ core_word;
  assign next_key[95:64]  = prev_key[95:64]  ^ next_key[127:96];
  assign next_key[63:32]  = prev_key[63:32]  ^ next_key[95:64];
  assign next_key[31:0]   = prev_key[31:0]   ^ next_key[63:32];

endmodule

// File: rtl/key_expansion_ctrl.sv
// Iterative AES-128 key expansion into an 11-entry round-key file with a
// registered read port. Optional KEYEXP_CACHE_EN skips re-expanding the same key.
module key_expansion_ctrl
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
  output logic         key_busy,
  output logic         key_ready,
  input  logic         rk_rd_en,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data,
  output logic         rk_valid
);

  state_t     state_reg, state_next;
  logic [3:0] rnd_reg, rnd_next;
  rkey_t      work_reg, work_next;
  logic       ready_reg, ready_next;

  rkey_t      rk_mem [NUM_RKEYS];
  logic       wr_en;
  logic [3:0] wr_addr;
  rkey_t      wr_data;

  rkey_t      step_key;
  logic [3:0] step_round;
  logic       cache_hit;
  logic       load_accept;
  logic       expand_done;

  assign step_round  = rnd_reg - 4'd1;
  assign expand_done = (state_reg == EXPAND) && (rnd_reg == LAST_RND);

  key_round_step u_step (
    .prev_key     (work_reg),
    .round_number (step_round),
    .next_key     (step_key)
  );

`ifdef KEYEXP_CACHE_EN
  rkey_t tag_reg;
  logic  tag_valid_reg;

  // rk[0] still holds the cipher key when the last round key lands.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tag_reg       <= '0;
      tag_valid_reg <= 1'b0;
    end else if (expand_done) begin
      tag_reg       <= rk_mem[0];
      tag_valid_reg <= 1'b1;
    end else if (load_accept) begin
      tag_valid_reg <= 1'b0;
    end
  end

  assign cache_hit = (state_reg == READY) && tag_valid_reg && (key_in == tag_reg);
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= IDLE;
      rnd_reg   <= 4'd0;
      work_reg  <= '0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      rnd_reg   <= rnd_next;
      work_reg  <= work_next;
      ready_reg <= ready_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    rnd_next    = rnd_reg;
    work_next   = work_reg;
    ready_next  = ready_reg;
    wr_en       = 1'b0;
    wr_addr     = rnd_reg;
    wr_data     = step_key;
    load_accept = 1'b0;
    case (state_reg)
      IDLE, READY: begin
        if (key_load && !cache_hit) begin
          load_accept = 1'b1;
          wr_en       = 1'b1;
          wr_addr     = 4'd0;
          wr_data     = key_in;
          work_next   = key_in;
          rnd_next    = 4'd1;
          ready_next  = 1'b0;
          state_next  = EXPAND;
        end
      end
      EXPAND: begin
        wr_en     = 1'b1;
        work_next = step_key;
        if (rnd_reg == LAST_RND) begin
          ready_next = 1'b1;
          state_next = READY;
        end else begin
          rnd_next = rnd_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_RKEYS; i++) rk_mem[i] <= '0;
    end else if (wr_en) begin
      rk_mem[wr_addr] <= wr_data;
    end
  end

  // Reads look at the registered ready flag, so a load on the same edge
  // still returns the previous key's entry.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rk_data  <= '0;
      rk_valid <= 1'b0;
    end else if (rk_rd_en && ready_reg && (rk_addr <= LAST_RND)) begin
      rk_data  <= rk_mem[rk_addr];
      rk_valid <= 1'b1;
    end else begin
      rk_data  <= '0;
      rk_valid <= 1'b0;
    end
  end

  assign key_busy  = (state_reg == EXPAND);
  assign key_ready = ready_reg;

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Self-checking bench for key_expansion_ctrl against a FIPS-197 style
// word-by-word key expansion model with a computed S-box.
module tb_key_expansion_ctrl;

  logic         clk;
  logic         n_rst;
  logic         key_load;
  logic [127:0] key_in;
  logic         key_busy;
  logic         key_ready;
  logic         rk_rd_en;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic         rk_valid;

  int errors = 0;
  int checks = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [11];

  key_expansion_ctrl dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .key_load  (key_load),
    .key_in    (key_in),
    .key_busy  (key_busy),
    .key_ready (key_ready),
    .rk_rd_en  (rk_rd_en),
    .rk_addr   (rk_addr),
    .rk_data   (rk_data),
    .rk_valid  (rk_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from the GF(2^8) inverse and the affine transform.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_load(input logic [127:0] k);
    key_load = 1'b1;
    key_in   = k;
    step();
    key_load = 1'b0;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!key_ready && cycles < 30) begin
      step();
      cycles++;
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [127:0] d, output logic v);
    rk_rd_en = 1'b1;
    rk_addr  = a;
    step();
    d = rk_data;
    v = rk_valid;
    rk_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({key_busy, key_ready, rk_valid} !== 3'b000 || rk_data !== 128'h0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b ready=%b valid=%b data=%h required all 0",
               key_busy, key_ready, rk_valid, rk_data);
    end
    step();
    n_rst = 1'b1;
    step();
    begin
      logic [127:0] d;
      logic v;
      rd(4'd0, d, v);
      checks++;
      if (v !== 1'b0 || d !== 128'h0 || key_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_read: got valid=%b data=%h ready=%b required 0", v, d, key_ready);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_fips();
    logic [127:0] d;
    logic v;
    int cyc;
    model_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    do_load(128'h2b7e151628aed2a6abf7158809cf4f3c);
    checks++;
    if (key_busy !== 1'b1 || key_ready !== 1'b0) begin
      errors++;
      $display("FAIL fips_busy: got busy=%b ready=%b required busy=1 ready=0", key_busy, key_ready);
    end
    wait_ready(cyc);
    checks++;
    if (cyc != 10 || key_busy !== 1'b0) begin
      errors++;
      $display("FAIL fips_latency: got %0d cycles busy=%b required 10 cycles busy=0", cyc, key_busy);
    end
    // Back-to-back sweep of the whole address space.
    for (int a = 0; a < 16; a++) begin
      rk_rd_en = 1'b1;
      rk_addr  = 4'(a);
      step();
      checks++;
      if (a <= 10) begin
        if (rk_valid !== 1'b1 || rk_data !== exp_rk[a]) begin
          errors++;
          $display("FAIL sweep_rk%0d: got valid=%b data=%h required valid=1 data=%h",
                   a, rk_valid, rk_data, exp_rk[a]);
        end
      end else if (rk_valid !== 1'b0 || rk_data !== 128'h0) begin
        errors++;
        $display("FAIL sweep_oob%0d: got valid=%b data=%h required 0", a, rk_valid, rk_data);
      end
    end
    rk_rd_en = 1'b0;
    step();
    checks++;
    if (rk_valid !== 1'b0 || rk_data !== 128'h0) begin
      errors++;
      $display("FAIL read_not_held: got valid=%b data=%h required 0", rk_valid, rk_data);
    end
    rd(4'd1, d, v);
    checks++;
    if (v !== 1'b1 || d !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      errors++;
      $display("FAIL fips_rk1: got %h required a0fafe1788542cb123a339392a6c7605", d);
    end
    rd(4'd10, d, v);
    checks++;
    if (v !== 1'b1 || d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++;
      $display("FAIL fips_rk10: got %h required d014f9a8c9ee2589e13f0cc8b6630ca6", d);
    end
    $display("test_fips done latency=%0d", cyc);
  endtask

  task automatic test_expand_reads();
    logic [127:0] k1, k2, d;
    logic v;
    int cyc = 0;
    k1 = rand_key();
    k2 = ~k1;
    model_expand(k1);
    do_load(k1);
    while (key_busy === 1'b1 && cyc < 30) begin
      rk_rd_en = 1'b1;
      rk_addr  = 4'($urandom_range(0, 10));
      key_load = (cyc == 3);
      key_in   = k2;
      step();
      key_load = 1'b0;
      cyc++;
      checks++;
      if (rk_valid !== 1'b0 || rk_data !== 128'h0) begin
        errors++;
        $display("FAIL expand_read%0d: got valid=%b data=%h required 0", cyc, rk_valid, rk_data);
      end
    end
    rk_rd_en = 1'b0;
    checks++;
    if (cyc != 10 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL expand_ignore_load: got %0d cycles ready=%b required 10 ready=1", cyc, key_ready);
    end
    for (int a = 0; a < 11; a += 5) begin
      rd(4'(a), d, v);
      checks++;
      if (v !== 1'b1 || d !== exp_rk[a]) begin
        errors++;
        $display("FAIL expand_result_rk%0d: got %h required %h", a, d, exp_rk[a]);
      end
    end
    $display("test_expand_reads done");
  endtask

  task automatic test_reset_mid();
    logic [127:0] d;
    logic v;
    int cyc;
    do_load(rand_key());
    repeat (4) step();
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({key_busy, key_ready, rk_valid} !== 3'b000 || rk_data !== 128'h0) begin
      errors++;
      $display("FAIL midreset_async: got busy=%b ready=%b valid=%b data=%h required 0",
               key_busy, key_ready, rk_valid, rk_data);
    end
    rk_rd_en = 1'b1;
    rk_addr  = 4'd0;
    step();
    step();
    checks++;
    if ({key_busy, key_ready, rk_valid} !== 3'b000 || rk_data !== 128'h0) begin
      errors++;
      $display("FAIL midreset_held: got busy=%b ready=%b valid=%b data=%h required 0",
               key_busy, key_ready, rk_valid, rk_data);
    end
    rk_rd_en = 1'b0;
    n_rst = 1'b1;
    step();
    model_expand(128'h000102030405060708090a0b0c0d0e0f);
    do_load(128'h000102030405060708090a0b0c0d0e0f);
    wait_ready(cyc);
    rd(4'd10, d, v);
    checks++;
    if (cyc != 10 || v !== 1'b1 || d !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
      errors++;
      $display("FAIL midreset_rk10: got %h latency %0d required 13111d7fe3944a17f307a78b4d2b30c5 latency 10",
               d, cyc);
    end
    rd(4'd5, d, v);
    checks++;
    if (v !== 1'b1 || d !== exp_rk[5]) begin
      errors++;
      $display("FAIL midreset_rk5: got %h required %h", d, exp_rk[5]);
    end
    $display("test_reset_mid done");
  endtask

  // Key currently expanded is the one left by test_reset_mid.
  task automatic test_reload();
    logic [127:0] k, d;
    logic v;
    int cyc;
    k = 128'h000102030405060708090a0b0c0d0e0f;
    do_load(k);
`ifdef KEYEXP_CACHE_EN
    checks++;
    if (key_busy !== 1'b0 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL cache_hit: got busy=%b ready=%b required busy=0 ready=1", key_busy, key_ready);
    end
    rd(4'd10, d, v);
    checks++;
    if (v !== 1'b1 || d !== exp_rk[10]) begin
      errors++;
      $display("FAIL cache_file: got %h required %h", d, exp_rk[10]);
    end
`else
    checks++;
    if (key_busy !== 1'b1 || key_ready !== 1'b0) begin
      errors++;
      $display("FAIL reload_reexpand: got busy=%b ready=%b required busy=1 ready=0", key_busy, key_ready);
    end
    wait_ready(cyc);
    rd(4'd10, d, v);
    checks++;
    if (cyc != 10 || v !== 1'b1 || d !== exp_rk[10]) begin
      errors++;
      $display("FAIL reload_result: got %h latency %0d required %h latency 10", d, cyc, exp_rk[10]);
    end
`endif
    k = rand_key();
    model_expand(k);
    do_load(k);
    wait_ready(cyc);
    rd(4'd7, d, v);
    checks++;
    if (cyc != 10 || v !== 1'b1 || d !== exp_rk[7]) begin
      errors++;
      $display("FAIL reload_differ: got %h latency %0d required %h latency 10", d, cyc, exp_rk[7]);
    end
    $display("test_reload done");
  endtask

  task automatic test_simul_load_read();
    logic [127:0] old10, k2;
    int cyc;
    old10 = exp_rk[10];
    k2 = rand_key();
    key_load = 1'b1;
    key_in   = k2;
    rk_rd_en = 1'b1;
    rk_addr  = 4'd10;
    step();
    key_load = 1'b0;
    checks++;
    if (rk_valid !== 1'b1 || rk_data !== old10) begin
      errors++;
      $display("FAIL simul_old: got valid=%b data=%h required valid=1 data=%h", rk_valid, rk_data, old10);
    end
    step();
    rk_rd_en = 1'b0;
    checks++;
    if (rk_valid !== 1'b0 || rk_data !== 128'h0 || key_ready !== 1'b0) begin
      errors++;
      $display("FAIL simul_next: got valid=%b data=%h ready=%b required 0", rk_valid, rk_data, key_ready);
    end
    model_expand(k2);
    wait_ready(cyc);
    $display("test_simul_load_read done");
  endtask

  task automatic test_random();
    logic [127:0] k, d;
    logic v;
    logic [3:0] a;
    int cyc;
    for (int n = 0; n < 3; n++) begin
      k = rand_key();
      model_expand(k);
      do_load(k);
      wait_ready(cyc);
      checks++;
      if (cyc != 10) begin
        errors++;
        $display("FAIL random_latency%0d: got %0d required 10", n, cyc);
      end
      for (int r = 0; r < 8; r++) begin
        a = 4'($urandom_range(0, 15));
        rd(a, d, v);
        checks++;
        if (a <= 4'd10 ? (v !== 1'b1 || d !== exp_rk[a]) : (v !== 1'b0 || d !== 128'h0)) begin
          errors++;
          $display("FAIL random_read k%0d addr%0d: got valid=%b data=%h required %h",
                   n, a, v, d, (a <= 4'd10) ? exp_rk[a] : 128'h0);
        end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    n_rst    = 1'b0;
    key_load = 1'b0;
    key_in   = '0;
    rk_rd_en = 1'b0;
    rk_addr  = '0;
    build_sbox();
    test_reset();
    test_fips();
    test_expand_reads();
    test_reset_mid();
    test_reload();
    test_simul_load_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_expansion_ctrl.md
# key_expansion_ctrl

Iterative AES-128 key-expansion controller. It accepts a 128-bit cipher key through a load handshake and computes one round key per clock with a single shared key-schedule-core instance. The 11 round keys go into an internal round-key file, which the encrypt/decrypt round datapath reads through a registered read port. It replaces the fully unrolled 10-core expansion when area matters more than expansion latency.

## Interface
- No parameters; AES-128 only (NR = 10, 11 round keys).
- clk  input  1  system clock, all state on rising edge
- n_rst  input  1  reset, asynchronous, active-low
- key_load  input  1  single-cycle request to expand key_in
- key_in  input  128  cipher key; word0 = [127:96], word3 = [31:0]
- key_busy  output  1  expansion in progress
- key_ready  output  1  all 11 round keys valid for the current key
- rk_rd_en  input  1  round-key read request
- rk_addr  input  4  round-key index 0..10
- rk_data  output  128  registered read data
- rk_valid  output  1  rk_data holds a legal, ready round key

## Operation
- FSM states: IDLE, EXPAND, READY.
- IDLE:
  - key_load=1 → write key_in to rk[0], load working key, round counter rnd=1 → EXPAND.
- EXPAND, each cycle:
  - w = keyScheduleCore(prev[31:0], roundNumber = rnd-1).
  - new[127:96] = prev[127:96]^w; each next word = prev word ^ new previous word.
  - Write new to rk[rnd] and to the working key; rnd++.
  - After the rnd=10 write → READY.
- READY:
  - key_load=1 restarts exactly as from IDLE: rk[0] overwritten, key_ready drops.
- key_load while key_busy=1 is ignored. There is no queuing, and the requester must retry.
- key_ready is cleared on the accepted load edge and set on the edge that writes rk[10].
- Read port:
  - On each edge, rk_valid <= rk_rd_en & key_ready & (rk_addr <= 10).
  - rk_data <= rk[rk_addr] when that condition holds, else 128'h0.
  - A read with rk_rd_en=0 leaves rk_data/rk_valid at 0 (they are not held).
- Reads during EXPAND return rk_valid=0 and rk_data=0; partial keys are never exposed.
- Simultaneous key_load and rk_rd_en in READY: the read samples the old key_ready=1 and returns the old key's round key. From the next cycle reads are invalid.
- The rnd counter is 4 bits and never exceeds 10.

## Timing
- Reset values:
  - key_busy=0, key_ready=0, rk_valid=0, rk_data=0.
  - FSM=IDLE, rnd=0, round-key file all zero.
- Load accepted at edge E0 → key_busy=1 from E0 to E10. rk[i] is written at edge Ei.
- key_ready=1 and key_busy=0 after E10. Load-to-ready latency is 10 cycles.
- Read latency is 1 cycle: request at edge Rn, data at edge Rn+1.
- Back-to-back reads give one result per cycle.
- Reset asserted mid-expansion returns everything immediately to the reset values. The partial key is discarded.

## Configuration
- KEYEXP_CACHE_EN defined:
  - A 128-bit tag register holds the last fully expanded key.
  - key_load in READY with key_in == tag → no re-expansion. key_ready stays 1, key_busy stays 0, and the file is untouched.
  - The tag is cleared by reset, written when rk[10] completes, and invalidated on any accepted differing load.
- Macro undefined: every accepted load re-expands, and there is no tag register.

## Structure
- Shared package aes_pkg holds:
  - NUM_ROUNDS = 10 and NUM_RKEYS = 11.
  - typedef rkey_t (logic [127:0]).
  - typedef state_t enum {IDLE, EXPAND, READY}.
- Sub-module key_round_step (combinational):
  - Ports: prev key, 4-bit roundNumber, next key.
  - Wraps one keyScheduleCore plus the four-word XOR chain.
- Round-key file and FSM stay in key_expansion_ctrl.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - key_ready rises exactly 10 cycles after the load edge.
  - rk[1] = a0fafe1788542cb123a339392a6c7605.
  - rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Sweep reads of rk_addr 0..15 in READY:
  - 0..10 return the golden schedule with rk_valid=1.
  - 11..15 return rk_valid=0 and rk_data=0.
- Reads and a second key_load issued during EXPAND:
  - Reads return rk_valid=0.
  - The second load is ignored, and the result matches the first key.
- Assert n_rst at the 5th EXPAND cycle, then release and load key 000102030405060708090a0b0c0d0e0f:
  - All outputs are 0 during reset.
  - rk[10] = 13111d7fe3944a17f307a78b4d2b30c5.
- With KEYEXP_CACHE_EN, reload the identical key in READY:
  - key_busy stays 0 and key_ready stays 1.
  - A differing key triggers the full 10-cycle expansion.
- Same-cycle key_load and rk_rd_en(addr=10) in READY:
  - Returns the old key's rk[10] with rk_valid=1.
  - The next cycle's read returns rk_valid=0.
